// File: rtl/sl_preceptron_pkg.sv
// Shared types and default geometry for the perceptron job controller.
// Provides the state encoding and the counter-width helper used by the controller files.
package sl_preceptron_pkg;

  localparam int DEF_DATA_IN_LANES  = 4;
  localparam int DEF_DATA_IN_WIDTH  = 8;
  localparam int DEF_MEM_ADDR_WIDTH = 16;
  localparam int DEF_WEIGHTS_WIDTH  = 8;
  localparam int DEF_VECTOR_LENGTH  = 64;
  localparam int DEF_SUM_WIDTH      = 24;
  localparam int DEF_TIMEOUT_CCS    = 256;

  localparam int BEATS               = DEF_VECTOR_LENGTH / DEF_DATA_IN_LANES;
  localparam int TOTAL_DATA_IN_WIDTH = DEF_DATA_IN_LANES * DEF_DATA_IN_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_STREAM = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  // A counter that must be able to hold its terminal value without wrapping.
  function automatic int cnt_width(input int terminal);
    return $clog2(terminal + 1);
  endfunction

endpackage

// File: rtl/sl_preceptron_wload.sv
// Weight loader: copies VECTOR_LENGTH weights from the external store into the
// perceptron weight RAM, one read per cycle with the write trailing by one cycle.
module sl_preceptron_wload
  import sl_preceptron_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int WEIGHTS_WIDTH  = DEF_WEIGHTS_WIDTH,
  parameter int VECTOR_LENGTH  = DEF_VECTOR_LENGTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [MEM_ADDR_WIDTH-1:0] wbase,
  output logic                      done,
  output logic                      wsrc_ren,
  output logic [MEM_ADDR_WIDTH-1:0] wsrc_addr,
  input  logic [WEIGHTS_WIDTH-1:0]  wsrc_rdata,
  output logic                      pe_mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] pe_mem_addr,
  output logic [WEIGHTS_WIDTH-1:0]  pe_mem_wdata
);

  localparam int                RCNT_W    = cnt_width(VECTOR_LENGTH);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(VECTOR_LENGTH);

  logic                      active;
  logic [RCNT_W-1:0]         rd_cnt;
  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic                      wen_q;
  logic [MEM_ADDR_WIDTH-1:0] waddr_q;
  logic                      reading;

  assign reading = active && (rd_cnt != RCNT_LAST);
  // Done coincides with the final write, so the loader spans VECTOR_LENGTH+1 cycles.
  assign done    = active && (rd_cnt == RCNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      rd_cnt  <= '0;
      base_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
    end else begin
      wen_q <= reading;
      if (reading) begin
        waddr_q <= MEM_ADDR_WIDTH'(rd_cnt);
      end
      if (start) begin
        active <= 1'b1;
        rd_cnt <= '0;
        base_q <= wbase;
      end else if (done) begin
        active <= 1'b0;
      end else if (reading) begin
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Store data arrives one cycle after the read, aligned with the registered write strobe.
  assign wsrc_ren     = reading;
  assign wsrc_addr    = reading ? (base_q + MEM_ADDR_WIDTH'(rd_cnt)) : '0;
  assign pe_mem_wen   = wen_q;
  assign pe_mem_addr  = wen_q ? waddr_q : '0;
  assign pe_mem_wdata = wen_q ? wsrc_rdata : '0;

endmodule

// File: rtl/sl_preceptron_job_ctrl.sv
// Job sequencer in front of the perceptron: load weights, program threshold,
// stream samples, then wait for the MAC result (or time out) and hand it back.
module sl_preceptron_job_ctrl
  import sl_preceptron_pkg::*;
#(
  parameter int DATA_IN_LANES  = DEF_DATA_IN_LANES,
  parameter int DATA_IN_WIDTH  = DEF_DATA_IN_WIDTH,
  parameter int MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
  parameter int WEIGHTS_WIDTH  = DEF_WEIGHTS_WIDTH,
  parameter int VECTOR_LENGTH  = DEF_VECTOR_LENGTH,
  parameter int SUM_WIDTH      = DEF_SUM_WIDTH,
  parameter int TIMEOUT_CCS    = DEF_TIMEOUT_CCS
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   job_valid,
  output logic                                   job_ready,
  input  logic [MEM_ADDR_WIDTH-1:0]              job_wbase,
  input  logic [SUM_WIDTH-1:0]                   job_threshold,
  output logic                                   wsrc_ren,
  output logic [MEM_ADDR_WIDTH-1:0]              wsrc_addr,
  input  logic [WEIGHTS_WIDTH-1:0]               wsrc_rdata,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] s_data,
  output logic                                   pe_mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0]              pe_mem_addr,
  output logic [WEIGHTS_WIDTH-1:0]               pe_mem_wdata,
  output logic                                   pe_data_valid,
  output logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] pe_data_in,
  output logic [SUM_WIDTH-1:0]                   pe_cfg_ai_threshold,
  input  logic                                   pe_done,
  input  logic [SUM_WIDTH-1:0]                   pe_ai_sum,
  input  logic                                   pe_ai_comparator,
  output logic                                   res_valid,
  input  logic                                   res_ready,
  output logic [SUM_WIDTH-1:0]                   res_sum,
  output logic                                   res_comp,
  output logic                                   res_err,
  output logic                                   busy
);

  localparam int                NBEATS    = VECTOR_LENGTH / DATA_IN_LANES;
  localparam int                BCNT_W    = cnt_width(NBEATS);
  localparam int                TCNT_W    = cnt_width(TIMEOUT_CCS);
  localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(NBEATS - 1);
  localparam logic [BCNT_W-1:0] BEAT_END  = BCNT_W'(NBEATS);
  localparam logic [TCNT_W-1:0] TO_LAST   = TCNT_W'(TIMEOUT_CCS - 1);

  state_t              state;
  state_t              next_state;
  logic                job_accept;
  logic                beat_accept;
  logic                wl_done;
  logic [BCNT_W-1:0]   beat_cnt;
  logic [TCNT_W-1:0]   to_cnt;
  logic [SUM_WIDTH-1:0] thr_q;

  assign job_accept  = job_valid && job_ready;
  assign beat_accept = s_valid && s_ready;
  assign busy        = (state != ST_IDLE);

  sl_preceptron_wload #(
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH),
    .WEIGHTS_WIDTH (WEIGHTS_WIDTH),
    .VECTOR_LENGTH (VECTOR_LENGTH)
  ) u_wload (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (job_accept),
    .wbase       (job_wbase),
    .done        (wl_done),
    .wsrc_ren    (wsrc_ren),
    .wsrc_addr   (wsrc_addr),
    .wsrc_rdata  (wsrc_rdata),
    .pe_mem_wen  (pe_mem_wen),
    .pe_mem_addr (pe_mem_addr),
    .pe_mem_wdata(pe_mem_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    job_ready  = 1'b0;
    s_ready    = 1'b0;
    res_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (wl_done) next_state = ST_STREAM;
      end
      ST_STREAM: begin
        s_ready = (beat_cnt != BEAT_END);
        if (s_valid && s_ready && (beat_cnt == BEAT_LAST)) next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (pe_done || (to_cnt == TO_LAST)) next_state = ST_RESULT;
      end
      ST_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Beats are re-timed by one register; stall cycles drive zero data, not stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q         <= '0;
      beat_cnt      <= '0;
      to_cnt        <= '0;
      pe_data_valid <= 1'b0;
      pe_data_in    <= '0;
      res_sum       <= '0;
      res_comp      <= 1'b0;
      res_err       <= 1'b0;
    end else begin
      pe_data_valid <= beat_accept;
      pe_data_in    <= beat_accept ? s_data : '0;
      if (job_accept) begin
        thr_q    <= job_threshold;
        beat_cnt <= '0;
        to_cnt   <= '0;
      end
      if (beat_accept) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (state == ST_WAIT) begin
        to_cnt <= to_cnt + 1'b1;
        if (pe_done) begin
          res_sum  <= pe_ai_sum;
          res_comp <= pe_ai_comparator;
          res_err  <= 1'b0;
        end else if (to_cnt == TO_LAST) begin
          res_sum  <= '0;
          res_comp <= 1'b0;
          res_err  <= 1'b1;
        end
      end
    end
  end

  assign pe_cfg_ai_threshold = thr_q;

endmodule

// File: doc/sl_preceptron_job_ctrl.md
Name: sl_preceptron_job_ctrl

Overview:
- Job sequencer in front of sl_preceptron_top; replaces the manual weight-write/data-drive/result-check sequence.
- For each accepted job it:
  - copies VECTOR_LENGTH weights from an external weight store into the perceptron weight RAM;
  - programs the threshold;
  - streams VECTOR_LENGTH samples from a valid/ready source;
  - waits for MAC done and returns sum/comparator on a valid/ready result port.
- Sits between the host/stream fabric and sl_preceptron_top.

Parameters:
- DATA_IN_LANES, 4, samples per data beat
- DATA_IN_WIDTH, 8, bits per sample
- MEM_ADDR_WIDTH, 16, weight address width (store and perceptron RAM)
- WEIGHTS_WIDTH, 8, bits per weight
- VECTOR_LENGTH, 64, weights/samples per job; must be divisible by DATA_IN_LANES
- SUM_WIDTH, 24, accumulator/threshold width
- TIMEOUT_CCS, 256, max cycles in WAIT before abort

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- job_valid  in  1  job request
- job_ready  out  1  high only in IDLE
- job_wbase  in  MEM_ADDR_WIDTH  weight-store base address
- job_threshold  in  SUM_WIDTH  threshold for this job
- wsrc_ren  out  1  weight-store read enable
- wsrc_addr  out  MEM_ADDR_WIDTH  weight-store address
- wsrc_rdata  in  WEIGHTS_WIDTH  read data, valid 1 cycle after wsrc_ren
- s_valid  in  1  sample beat valid
- s_ready  out  1  sample beat ready
- s_data  in  DATA_IN_LANES*DATA_IN_WIDTH  lane0 in LSBs
- pe_mem_wen  out  1  perceptron weight write
- pe_mem_addr  out  MEM_ADDR_WIDTH  perceptron weight address
- pe_mem_wdata  out  WEIGHTS_WIDTH  perceptron weight data
- pe_data_valid  out  1  perceptron data valid
- pe_data_in  out  DATA_IN_LANES*DATA_IN_WIDTH  perceptron data
- pe_cfg_ai_threshold  out  SUM_WIDTH  threshold to perceptron
- pe_done  in  1  one-cycle pulse on MAC done state
- pe_ai_sum  in  SUM_WIDTH  perceptron status sum
- pe_ai_comparator  in  1  perceptron comparator
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_sum  out  SUM_WIDTH  captured sum
- res_comp  out  1  captured comparator
- res_err  out  1  1 = job timed out; sum/comp forced 0
- busy  out  1  state != IDLE

Behaviour:

Reset:
- All outputs 0 except job_ready = 1 (IDLE).
- Counters cleared; threshold register 0.
- Reset asserted mid-job aborts immediately; no partial result is emitted.

States:
- IDLE:
  - job_ready = 1.
  - On job_valid, latch wbase/threshold, clear counters, go to LOAD.
  - pe_cfg_ai_threshold updates the cycle after accept and holds until the next accept.
- LOAD:
  - Read counter r = 0..VECTOR_LENGTH-1: wsrc_ren = 1, wsrc_addr = wbase + r (modulo 2^MEM_ADDR_WIDTH, wraps silently).
  - One cycle after each read: pe_mem_wen = 1, pe_mem_addr = r, pe_mem_wdata = wsrc_rdata (registered).
  - LOAD lasts exactly VECTOR_LENGTH+1 cycles (64 reads, 65 cycles to last write), then STREAM.
- STREAM:
  - s_ready = 1 while beat count < VECTOR_LENGTH/DATA_IN_LANES.
  - Each s_valid&s_ready beat is registered to pe_data_valid/pe_data_in one cycle later.
  - Stalls (s_valid = 0) produce pe_data_valid = 0 and pe_data_in = 0.
  - After the last beat is accepted, go to WAIT; the last pe_data_valid occurs in the first WAIT cycle.
- WAIT:
  - Timeout counter increments each cycle.
  - On pe_done: capture pe_ai_sum/pe_ai_comparator, res_err = 0, go to RESULT.
  - If the counter reaches TIMEOUT_CCS without pe_done: res_sum = 0, res_comp = 0, res_err = 1, go to RESULT.
  - pe_done and timeout in the same cycle: pe_done wins.
- RESULT:
  - res_valid = 1; res_* stable until res_ready.
  - On res_valid&res_ready, go to IDLE next cycle. No bypass: the next job is accepted at earliest in the cycle after RESULT exits.

Boundary conditions:
- pe_done outside WAIT is ignored.
- job_valid outside IDLE is not accepted (job_ready = 0).
- s_valid outside STREAM is not accepted (s_ready = 0).
- Beat counter and read counter widths are $clog2 of their terminal count + 1; no overflow.

Decomposition:
- sl_preceptron_pkg:
  - state encoding (IDLE = 0, LOAD = 1, STREAM = 2, WAIT = 3, RESULT = 4);
  - localparam BEATS = VECTOR_LENGTH/DATA_IN_LANES;
  - TOTAL_DATA_IN_WIDTH.
- One sub-module: sl_preceptron_wload.
  - Read/write counter pipeline; start/done handshake; owns the wsrc_* and pe_mem_* ports.
- FSM, stream, timeout and result logic stay in the top.

Test Plan:
- Nominal job: wbase = 0x0100, weights i+1, samples all 2, threshold 100.
  - 64 pe_mem writes with addr 0..63 and data 1..64.
  - 16 pe_data beats.
  - After pe_done, res_sum equals model sum, res_comp per threshold, res_err = 0.
- Address wrap: wbase = 0xFFF0.
  - wsrc_addr runs 0xFFF0..0xFFFF, then 0x0000..0x002F.
  - pe_mem_addr still runs 0..63.
- Stream stalls: s_valid toggled 1-0-1 randomly.
  - Exactly 16 pe_data_valid pulses, data order preserved.
  - s_ready drops after the 16th beat.
- Timeout: pe_done never pulsed.
  - RESULT entered exactly TIMEOUT_CCS = 256 cycles after WAIT entry, res_err = 1, sum = 0.
  - A spurious pe_done during LOAD is ignored.
- Result backpressure: res_ready held low 10 cycles.
  - res_valid and res_* stable throughout; job_ready = 0.
  - Second job accepted only after the handshake, then five back-to-back jobs all match.
- Reset mid-STREAM after 7 beats.
  - All outputs return to reset values asynchronously; no res_valid.
  - The next job runs cleanly from IDLE.
